// File: rtl/transmissor_serial_7bits.sv
// Serial transmitter for 7-bit words: start bit, 7 data bits LSB first, even parity, stop bit.
// Each bit is held for CICLOS_POR_BIT clocks; every output is driven directly from a flop.
module transmissor_serial_7bits #(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] entrada,
    input  logic       entrada_valida,
    output logic       pronto,
    output logic       saida_serial,
    output logic       ocupado,
    output logic [2:0] estado_dbg
);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } estado_t;

    estado_t    estado_q;
    logic [6:0] dado_q;
    logic       paridade_q;
    logic [7:0] cont_q;
    logic [7:0] cont_d;
    logic [2:0] indice_q;
    logic       saida_q;
    logic       pronto_q;
    logic       ocupado_q;
    logic       fim_bit;

    assign cont_d  = cont_q + 8'd1;
    assign fim_bit = (cont_q == 8'(CICLOS_POR_BIT - 1));

    // Handshake: a word transfers on a rising edge where entrada_valida and pronto are both 1.
    // pronto is high only while idle; the producer must hold entrada until it sees pronto.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q   <= OCIOSO;
            dado_q     <= 7'd0;
            paridade_q <= 1'b0;
            cont_q     <= 8'd0;
            indice_q   <= 3'd0;
            saida_q    <= 1'b1;
            pronto_q   <= 1'b1;
            ocupado_q  <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (entrada_valida) begin
                        estado_q   <= INICIO;
                        dado_q     <= entrada;
                        paridade_q <= ^entrada;
                        cont_q     <= 8'd0;
                        saida_q    <= 1'b0;
                        pronto_q   <= 1'b0;
                        ocupado_q  <= 1'b1;
                    end
                end
                INICIO: begin
                    if (fim_bit) begin
                        estado_q <= DADOS;
                        cont_q   <= 8'd0;
                        indice_q <= 3'd0;
                        saida_q  <= dado_q[0];
                        dado_q   <= {1'b0, dado_q[6:1]};
                    end else begin
                        cont_q <= cont_d;
                    end
                end
                DADOS: begin
                    // dado_q[0] always holds the next bit to put on the line
                    if (fim_bit) begin
                        cont_q <= 8'd0;
                        if (indice_q == 3'd6) begin
                            estado_q <= PARIDADE;
                            saida_q  <= paridade_q;
                        end else begin
                            indice_q <= indice_q + 3'd1;
                            saida_q  <= dado_q[0];
                            dado_q   <= {1'b0, dado_q[6:1]};
                        end
                    end else begin
                        cont_q <= cont_d;
                    end
                end
                PARIDADE: begin
                    if (fim_bit) begin
                        estado_q <= PARADA;
                        cont_q   <= 8'd0;
                        saida_q  <= 1'b1;
                    end else begin
                        cont_q <= cont_d;
                    end
                end
                PARADA: begin
                    if (fim_bit) begin
                        estado_q  <= OCIOSO;
                        cont_q    <= 8'd0;
                        saida_q   <= 1'b1;
                        pronto_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                    end else begin
                        cont_q <= cont_d;
                    end
                end
                default: begin
                    estado_q  <= OCIOSO;
                    cont_q    <= 8'd0;
                    saida_q   <= 1'b1;
                    pronto_q  <= 1'b1;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign pronto       = pronto_q;
    assign saida_serial = saida_q;
    assign ocupado      = ocupado_q;
    assign estado_dbg   = estado_q;

endmodule

// File: tb/tb_transmissor_serial_7bits.sv
// Bench for transmissor_serial_7bits: C=4 table-driven frames, back-to-back, abort, and a C=1 random sweep.
// Expected line values come from a frame model: start 0, data LSB first, even parity, stop 1.
module tb_transmissor_serial_7bits;

    localparam int C4 = 4;
    localparam int NV = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] ent4, ent1;
    logic       val4, val1;
    logic       pronto4, saida4, ocup4;
    logic       pronto1, saida1, ocup1;
    logic [2:0] est4, est1;
    logic [2:0] est4_idle, est1_idle;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    typedef struct {
        logic [6:0] word;
        logic       par;
        logic       disturb;
    } vec_t;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    transmissor_serial_7bits #(.CICLOS_POR_BIT(C4)) dut4 (
        .clk(clk), .rst_n(rst_n), .entrada(ent4), .entrada_valida(val4),
        .pronto(pronto4), .saida_serial(saida4), .ocupado(ocup4), .estado_dbg(est4)
    );

    transmissor_serial_7bits #(.CICLOS_POR_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .entrada(ent1), .entrada_valida(val1),
        .pronto(pronto1), .saida_serial(saida1), .ocupado(ocup1), .estado_dbg(est1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic line_of(input int sel);
        return (sel == 1) ? saida1 : saida4;
    endfunction

    function automatic logic pronto_of(input int sel);
        return (sel == 1) ? pronto1 : pronto4;
    endfunction

    function automatic logic ocup_of(input int sel);
        return (sel == 1) ? ocup1 : ocup4;
    endfunction

    // Expected line for one frame: ten bit slots, each repeated c times.
    task automatic push_frame(input int c, input logic [6:0] word, input logic par);
        logic b;
        for (int s = 0; s < 10; s++) begin
            if (s == 0)      b = 1'b0;
            else if (s <= 7) b = word[s-1];
            else if (s == 8) b = par;
            else             b = 1'b1;
            for (int k = 0; k < c; k++) exp_q.push_back(b);
        end
    endtask

    task automatic wait_ready(input int sel);
        int n;
        n = 0;
        while (pronto_of(sel) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge of the first frame cycle.
    task automatic start_frame(input int sel, input logic [6:0] word);
        wait_ready(sel);
        if (sel == 1) begin ent1 = word; val1 = 1'b1; end
        else          begin ent4 = word; val4 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        if (sel == 1) val1 = 1'b0;
        else          val4 = 1'b0;
    endtask

    task automatic capture(input int sel, input int c, input logic disturb, input string name);
        int   n, busy;
        logic s, e;
        n = 10 * c;
        busy = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            s = line_of(sel);
            e = exp_q.pop_front();
            busy += int'(ocup_of(sel));
            check($sformatf("%s_line[%0d]", name, i), 32'(s), 32'(e));
            if (disturb && sel == 4) begin
                ent4 = 7'($urandom_range(0, 127));
                val4 = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        check({name, "_busy_cycles"}, 32'(busy), 32'(n));
        @(negedge clk);
        check({name, "_pronto_after"}, 32'(pronto_of(sel)), 32'd1);
        check({name, "_ocupado_after"}, 32'(ocup_of(sel)), 32'd0);
        check({name, "_line_idle"}, 32'(line_of(sel)), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       s;
        logic [6:0] w, w_r;
        logic       seq[10];
        int         second_start, busy;

        vecs[0] = '{7'h55, 1'b0, 1'b0};
        vecs[1] = '{7'h07, 1'b1, 1'b0};
        vecs[2] = '{7'h2A, 1'b1, 1'b1};
        vecs[3] = '{7'h01, 1'b1, 1'b0};
        vecs[4] = '{7'h63, 1'b0, 1'b0};

        // Reset held 3 cycles with a word offered: nothing may start
        rst_n = 1'b0;
        ent4  = vecs[0].word;
        val4  = 1'b1;
        ent1  = 7'd0;
        val1  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_line[%0d]", i), 32'(saida4), 32'd1);
            check($sformatf("rst_pronto[%0d]", i), 32'(pronto4), 32'd1);
            check($sformatf("rst_ocupado[%0d]", i), 32'(ocup4), 32'd0);
        end
        est4_idle = est4;
        est1_idle = est1;

        // Table frames at C=4; the first one is the word held through reset
        for (int v = 0; v < NV; v++) begin
            if (v == 0) begin
                rst_n = 1'b1;
                @(posedge clk);
                @(negedge clk);
                val4 = 1'b0;
            end else begin
                start_frame(4, vecs[v].word);
            end
            push_frame(C4, vecs[v].word, vecs[v].par);
            capture(4, C4, vecs[v].disturb, $sformatf("frame_%02h", vecs[v].word));
            check($sformatf("frame_%02h_state_idle", vecs[v].word), 32'(est4), 32'(est4_idle));
        end

        // Back-to-back with valid held high: 7F then 00
        ent4 = 7'h7F;
        val4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        push_frame(C4, 7'h7F, 1'b1);
        exp_q.push_back(1'b1);
        push_frame(C4, 7'h00, 1'b0);
        second_start = -1;
        for (int i = 0; i < 81; i++) begin
            if (i > 0) @(negedge clk);
            s = saida4;
            check($sformatf("b2b_line[%0d]", i), 32'(s), 32'(exp_q.pop_front()));
            if (i == 0) ent4 = 7'h00;
            if (i == 40) check("b2b_pronto_gap", 32'(pronto4), 32'd1);
            if (i == 41) val4 = 1'b0;
            if (i > 40 && s == 1'b0 && second_start < 0) second_start = i;
        end
        // start-to-start distance is 10C+1 cycles
        check("b2b_second_start", 32'(second_start), 32'(10 * C4 + 1));
        for (int i = 0; i < C4; i++) @(negedge clk);
        check("b2b_pronto_end", 32'(pronto4), 32'd1);

        // Abort during DADOS of a 2A frame
        start_frame(4, 7'h2A);
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("abort_pre_line", 32'(saida4), 32'd1);
        check("abort_pre_state", 32'(est4 != est4_idle), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_line", 32'(saida4), 32'd1);
        check("abort_ocupado", 32'(ocup4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_pronto_release", 32'(pronto4), 32'd1);
        check("abort_line_release", 32'(saida4), 32'd1);
        start_frame(4, 7'h2A);
        push_frame(C4, 7'h2A, 1'b1);
        capture(4, C4, 1'b0, "after_abort");

        // C=1 random sweep: rebuild each word from the captured line
        for (int f = 0; f < 128; f++) begin
            w = 7'($urandom_range(0, 127));
            start_frame(1, w);
            busy = 0;
            for (int i = 0; i < 10; i++) begin
                if (i > 0) @(negedge clk);
                seq[i] = saida1;
                busy += int'(ocup1);
            end
            for (int k = 0; k < 7; k++) w_r[k] = seq[k+1];
            check($sformatf("c1_start[%0d]", f), 32'(seq[0]), 32'd0);
            check($sformatf("c1_word[%0d]", f), 32'(w_r), 32'(w));
            check($sformatf("c1_parity[%0d]", f), 32'(seq[8]), 32'($countones(w) % 2));
            check($sformatf("c1_stop[%0d]", f), 32'(seq[9]), 32'd1);
            check($sformatf("c1_busy[%0d]", f), 32'(busy), 32'd10);
            @(negedge clk);
            check($sformatf("c1_pronto[%0d]", f), 32'(pronto1), 32'd1);
            check($sformatf("c1_state_idle[%0d]", f), 32'(est1), 32'(est1_idle));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
